ram8_bank: RTL and testbench

//   8-word x 16-bit register bank: the storage stage feeding the 8-way 16-bit read mux.

---
 rtl/ram8_bank_pkg.sv | 23 ++
 rtl/ram8_bank_if.sv | 33 +++
 rtl/ram8_bank_mux8way16.sv | 41 ++++
 rtl/ram8_bank.sv | 106 ++++++++++
 tb/tb_ram8_bank.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram8_bank_pkg.sv
// ============================================================================
//  Module   : ram8_pkg
//  Purpose  : Shared sizes, state encoding and word type for the ram8_bank slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ram8_pkg;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } ram8_state_t;

   typedef logic [WORD_W-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/ram8_bank_if.sv
// ============================================================================
//  Module   : ram8_bank_if
//  Purpose  : Write/read/clear bus of the 8-word register bank.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ram8_bank_if
   import ram8_pkg::*;
#(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0]  in;
   logic              load;
   logic [ADDR_W-1:0] address;
   logic              clr_req;
   logic [WIDTH-1:0]  out;
   logic              busy;
   logic              clr_done;

   modport master (
      output in, load, address, clr_req,
      input  out, busy, clr_done
   );

   modport slave (
      input  in, load, address, clr_req,
      output out, busy, clr_done
   );
endinterface

`default_nettype wire

// File: rtl/ram8_bank_mux8way16.sv
// ============================================================================
//  Module   : mux8way16
//  Purpose  : 8:1 word multiplexer used as the bank's combinational read path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mux8way16
   import ram8_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [WIDTH-1:0]  c,
   input  logic [WIDTH-1:0]  d,
   input  logic [WIDTH-1:0]  e,
   input  logic [WIDTH-1:0]  f,
   input  logic [WIDTH-1:0]  g,
   input  logic [WIDTH-1:0]  h,
   input  logic [ADDR_W-1:0] sel,
   output logic [WIDTH-1:0]  out
);
   always_comb begin
      out = a;
      case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         3'd7:    out = h;
         default: out = a;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/ram8_bank.sv
// ============================================================================
//  Module   : ram8_bank
//  Purpose  : 8 x WIDTH register bank, combinational read, sequenced clear engine.
//             Optional macro WRITE_BYPASS_EN forwards write data to out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram8_bank
   import ram8_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
   input  logic        clk,
   input  logic        rst_n,
   ram8_bank_if.slave  bus
);
   logic [WIDTH-1:0]  r_mem [DEPTH];
   ram8_state_t       r_state;
   logic [ADDR_W-1:0] r_clr_idx;
   logic              r_busy;
   logic              r_done;
   logic              w_wr_en;
   logic [WIDTH-1:0]  w_rd_data;

   // Host writes are dropped, not stalled, while the clear engine owns the array.
   assign w_wr_en = bus.load && (r_state != ST_CLEAR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_clr_idx <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.clr_req) begin
                  r_state   <= ST_CLEAR;
                  r_clr_idx <= '0;
                  r_busy    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (r_clr_idx == ADDR_W'(DEPTH - 1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == ST_CLEAR) begin
         r_mem[r_clr_idx] <= CLR_VALUE;
      end else if (w_wr_en) begin
         r_mem[bus.address] <= bus.in;
      end
   end

   mux8way16 #(
      .WIDTH (WIDTH)
   ) u_rd_mux (
      .a   (r_mem[0]),
      .b   (r_mem[1]),
      .c   (r_mem[2]),
      .d   (r_mem[3]),
      .e   (r_mem[4]),
      .f   (r_mem[5]),
      .g   (r_mem[6]),
      .h   (r_mem[7]),
      .sel (bus.address),
      .out (w_rd_data)
   );

`ifdef WRITE_BYPASS_EN
   // Single port: a live write always targets the address being read.
   assign bus.out = (bus.load && !r_busy) ? bus.in : w_rd_data;
`else
   assign bus.out = w_rd_data;
`endif

   assign bus.busy     = r_busy;
   assign bus.clr_done = r_done;
endmodule

`default_nettype wire

// File: tb/tb_ram8_bank.sv
// ============================================================================
//  Module   : tb_ram8_bank
//  Purpose  : Scoreboard testbench for ram8_bank (build with or without WRITE_BYPASS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram8_bank;
   import ram8_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   word_t model [DEPTH];
   word_t exp_q [$];
   word_t exp_v;

   ram8_bank_if #(.WIDTH(16)) bus ();

   ram8_bank #(.WIDTH(16), .CLR_VALUE(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_words(input word_t seed);
      for (int i = 0; i < DEPTH; i++) begin
         bus.address = 3'(i);
         bus.in      = seed ^ word_t'(16'h0101 * (i + 1));
         bus.load    = 1'b1;
         model[i]    = bus.in;
         tick();
      end
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in = '0; bus.load = 1'b0; bus.address = '0; bus.clr_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0)
         $display("FAIL reset_status: busy=%b clr_done=%b required 0/0", bus.busy, bus.clr_done);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < DEPTH; a++) begin
         bus.address = 3'(a);
         exp_q.push_back(model[a]);
         #1;
         exp_v = exp_q.pop_front();
         n_checks++;
         if (bus.out !== exp_v) $display("FAIL reset_read[%0d]: got %h required %h", a, bus.out, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_write();
      for (int i = 0; i < DEPTH; i++) begin
         bus.address = 3'(i);
         bus.in      = 16'h0001 << i;
         bus.load    = 1'b1;
         model[i]    = 16'h0001 << i;
         tick();
      end
      bus.load = 1'b0;
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h0080);
      bus.address = 3'd3;
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL write_read3: got %h required %h", bus.out, exp_v);
      else n_pass++;
      bus.address = 3'd7;
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL write_read7: got %h required %h", bus.out, exp_v);
      else n_pass++;
   endtask

   task automatic test_bypass();
      bus.address = 3'd5;
      bus.in      = 16'hBEEF;
      bus.load    = 1'b1;
`ifdef WRITE_BYPASS_EN
      exp_q.push_back(16'hBEEF);
`else
      exp_q.push_back(model[5]);
`endif
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL bypass_same_cycle: got %h required %h", bus.out, exp_v);
      else n_pass++;
      model[5] = 16'hBEEF;
      tick();
      bus.load = 1'b0;
      exp_q.push_back(model[5]);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL bypass_next_cycle: got %h required %h", bus.out, exp_v);
      else n_pass++;
   endtask

   task automatic test_clear();
      fill_words(16'hA5A5);
      // Write and clear request together: the write lands, the clear overwrites it later.
      bus.address = 3'd1; bus.in = 16'h5555; bus.load = 1'b1; bus.clr_req = 1'b1;
      model[1] = 16'h5555;
      tick();
      bus.load = 1'b0; bus.clr_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (bus.busy !== 1'b1 || bus.clr_done !== 1'b0)
            $display("FAIL clear_busy[%0d]: busy=%b clr_done=%b required 1/0", c, bus.busy, bus.clr_done);
         else n_pass++;
         if (c == 0) begin
            exp_q.push_back(model[1]);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (bus.out !== exp_v) $display("FAIL clear_load_commit: got %h required %h", bus.out, exp_v);
            else n_pass++;
         end
         tick();
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b1)
         $display("FAIL clear_done_pulse: busy=%b clr_done=%b required 0/1", bus.busy, bus.clr_done);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.clr_done !== 1'b0) $display("FAIL clear_done_width: clr_done=%b required 0", bus.clr_done);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int a = 0; a < DEPTH; a++) begin
         bus.address = 3'(a);
         exp_q.push_back(model[a]);
         #1;
         exp_v = exp_q.pop_front();
         n_checks++;
         if (bus.out !== exp_v) $display("FAIL clear_read[%0d]: got %h required %h", a, bus.out, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_during_clear();
      int cyc;
      fill_words(16'h3C3C);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      tick();
      tick();
      // Third clear cycle: word 6 is still the fill value in either build.
      bus.address = 3'd6; bus.in = 16'h1234; bus.load = 1'b1; bus.clr_req = 1'b1;
      exp_q.push_back(model[6]);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL busy_no_bypass: got %h required %h", bus.out, exp_v);
      else n_pass++;
      tick();
      bus.load = 1'b0; bus.clr_req = 1'b0;
      exp_q.push_back(model[6]);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL busy_write_dropped: got %h required %h", bus.out, exp_v);
      else n_pass++;
      cyc = 3;
      while (bus.clr_done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      n_checks++;
      if (cyc != 8) $display("FAIL busy_no_restart: done after %0d cycles required 8", cyc);
      else n_pass++;
      tick();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      bus.address = 3'd6;
      exp_q.push_back(model[6]);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL busy_read6: got %h required %h", bus.out, exp_v);
      else n_pass++;
   endtask

   task automatic test_reset_mid_clear();
      int saw_done;
      fill_words(16'h0F0F);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0)
         $display("FAIL abort_status: busy=%b clr_done=%b required 0/0", bus.busy, bus.clr_done);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      tick();
      rst_n = 1'b1;
      saw_done = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.clr_done === 1'b1) saw_done++;
         tick();
      end
      n_checks++;
      if (saw_done != 0) $display("FAIL abort_no_done: pulses=%0d required 0", saw_done);
      else n_pass++;
      for (int a = 0; a < DEPTH; a++) begin
         bus.address = 3'(a);
         exp_q.push_back(model[a]);
         #1;
         exp_v = exp_q.pop_front();
         n_checks++;
         if (bus.out !== exp_v) $display("FAIL abort_read[%0d]: got %h required %h", a, bus.out, exp_v);
         else n_pass++;
      end
      bus.address = 3'd2; bus.in = 16'h00AA; bus.load = 1'b1;
      model[2] = 16'h00AA;
      tick();
      bus.load = 1'b0;
      exp_q.push_back(model[2]);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.out !== exp_v) $display("FAIL abort_write_after: got %h required %h", bus.out, exp_v);
      else n_pass++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_bypass();
      test_clear();
      test_during_clear();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
